sev_seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/sev_seg_pkg.sv | 31 +++
 rtl/sev_seg_refresh_tick.sv | 29 ++
 rtl/sev_seg_scan_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types, code constants and segment decode for the 7-segment scan controller.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g} with bit 6 = a.
package sev_seg_pkg;

  typedef logic [3:0] digit_code_t;

  localparam digit_code_t CODE_DASH  = 4'd10;
  localparam digit_code_t CODE_BLANK = 4'd15;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  function automatic logic [6:0] seg_decode(input digit_code_t code);
    logic [6:0] seg;
    case (code)
      4'd0:      seg = 7'b0000001;
      4'd1:      seg = 7'b1001111;
      4'd2:      seg = 7'b0010010;
      4'd3:      seg = 7'b0000110;
      4'd4:      seg = 7'b1001100;
      4'd5:      seg = 7'b0100100;
      4'd6:      seg = 7'b1100000;
      4'd7:      seg = 7'b0001111;
      4'd8:      seg = 7'b0000000;
      4'd9:      seg = 7'b0001100;
      CODE_DASH: seg = 7'b1111110;
      default:   seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sev_seg_refresh_tick.sv
// Free-running prescaler 0..DIV-1: wrap flags the last count, blank_done flags count BLANK_LEN-1.
// Used for the digit slot timer and, when blinking is built in, for the blink phase timer.
module sev_seg_refresh_tick
  import sev_seg_pkg::*;
#(
  parameter int DIV       = 8,
  parameter int BLANK_LEN = 2,
  localparam int W        = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         blank_done
);

  localparam logic [W-1:0] LAST       = W'(DIV - 1);
  localparam logic [W-1:0] BLANK_LAST = W'(BLANK_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end

  assign wrap       = (cnt == LAST);
  assign blank_done = (cnt == BLANK_LAST);

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed scan controller for an N_DIG common-anode 7-segment display with anti-ghost blanking.
// Optional digit blinking is built in when SEV_SEG_BLINK_EN is defined.
//
//   state | meaning
//   BLANK | start of a digit slot, all anodes off while the previous digit's charge decays
//   DRIVE | anode of the current slot on, segments show its active code
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
`ifdef SEV_SEG_BLINK_EN
  ,
  parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic               load,
  input  logic               blank_lz,
`ifdef SEV_SEG_BLINK_EN
  input  logic [N_DIG-1:0]   blink_mask,
`endif
  output logic [N_DIG-1:0]   an_out,
  output logic [6:0]         seg_out,
  output logic               dp_out,
  output logic               frame_st
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick_wrap;
  logic          tick_blank_done;
  logic          unused_tick;
  logic [IW-1:0] idx;
  logic          frame_wrap;
  logic          blink_off;
  scan_state_t   state_q, state_d;

  digit_code_t [N_DIG-1:0] pend_code, act_code;
  logic [N_DIG-1:0]        pend_dp, act_dp;
  logic [N_DIG-1:0]        lz_blank;
  logic                    all_zero;
  digit_code_t             shown;
  logic [N_DIG-1:0]        an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  sev_seg_refresh_tick #(.DIV(TICK_DIV), .BLANK_LEN(BLANK_CYC)) u_slot_tick (
    .clk        (clk),
    .rst        (rst),
    .cnt        (tick_cnt),
    .wrap       (tick_wrap),
    .blank_done (tick_blank_done)
  );

  assign unused_tick = ^tick_cnt;
  assign frame_wrap  = tick_wrap && (idx == IDX_LAST);

`ifdef SEV_SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_wrap, blink_unused_done, blink_phase, unused_blink;

  sev_seg_refresh_tick #(.DIV(BLINK_DIV), .BLANK_LEN(1)) u_blink_tick (
    .clk        (clk),
    .rst        (rst),
    .cnt        (blink_cnt),
    .wrap       (blink_wrap),
    .blank_done (blink_unused_done)
  );

  assign unused_blink = ^{blink_cnt, blink_unused_done};

  always_ff @(posedge clk) begin
    if (rst)             blink_phase <= 1'b1;
    else if (blink_wrap) blink_phase <= ~blink_phase;
  end

  assign blink_off = ~blink_phase & blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // A digit is a leading zero when it and every more significant active code are zero.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int k = N_DIG - 1; k > 0; k--) begin
      all_zero    = all_zero & (act_code[k] == 4'd0);
      lz_blank[k] = blank_lz & all_zero;
    end
  end

  always_comb begin
    state_d = state_q;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    shown   = act_code[idx];
    case (state_q)
      BLANK: if (tick_blank_done) state_d = DRIVE;
      DRIVE: begin
        if (tick_wrap) state_d = BLANK;
        an_d[idx] = 1'b0;
        if (lz_blank[idx]) shown = CODE_BLANK;
        if (!blink_off) begin
          seg_d = seg_decode(shown);
          dp_d  = ~act_dp[idx];
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Active codes only change at frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      idx       <= '0;
      pend_code <= {N_DIG{CODE_BLANK}};
      act_code  <= {N_DIG{CODE_BLANK}};
      pend_dp   <= '0;
      act_dp    <= '0;
      an_out    <= '1;
      seg_out   <= 7'h7F;
      dp_out    <= 1'b1;
      frame_st  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tick_wrap) idx <= frame_wrap ? '0 : idx + IW'(1);
      if (load) begin
        pend_code <= digits_in;
        pend_dp   <= dp_in;
      end
      if (frame_wrap) begin
        act_code <= pend_code;
        act_dp   <= pend_dp;
      end
      an_out   <= an_d;
      seg_out  <= seg_d;
      dp_out   <= dp_d;
      frame_st <= frame_wrap;
    end
  end

endmodule
